// File: rtl/stream_mux2_rr.sv
// stream_mux2_rr: round-robin 2:1 valid/ready stream mux with one registered output stage.
// Define MUX_PKT_LOCK_EN to hold the grant from the first to the last beat of each packet.
module stream_mux2_rr #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in0_valid,
  input  logic [DATA_W-1:0] in0_data,
  input  logic              in0_last,
  output logic              in0_ready,
  input  logic              in1_valid,
  input  logic [DATA_W-1:0] in1_data,
  input  logic              in1_last,
  output logic              in1_ready,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last,
  output logic              out_src,
  input  logic              out_ready
);

  // Handshake: a beat moves on any edge where valid && ready are both high.
  // Ready may depend on valid, never the reverse; out_valid never drops without out_ready.
  localparam logic [1:0] ST_IDLE = 2'd0;

  logic [1:0]        lock_state;
  logic              last_grant;
  logic              load_en;
  logic              elig0;
  logic              elig1;
  logic              grant_any;
  logic              grant_sel;
  logic              accept;
  logic              acc_last;
  logic [DATA_W-1:0] acc_data;

  assign load_en = !out_valid || out_ready;

`ifdef MUX_PKT_LOCK_EN
  localparam logic [1:0] ST_LOCK0 = 2'd1;
  localparam logic [1:0] ST_LOCK1 = 2'd2;

  // While a packet is open only its own channel stays eligible.
  assign elig0 = in0_valid && (lock_state != ST_LOCK1);
  assign elig1 = in1_valid && (lock_state != ST_LOCK0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lock_state <= ST_IDLE;
    end else if (accept) begin
      if (acc_last) begin
        lock_state <= ST_IDLE;
      end else begin
        lock_state <= grant_sel ? ST_LOCK1 : ST_LOCK0;
      end
    end
  end
`else
  assign elig0      = in0_valid;
  assign elig1      = in1_valid;
  assign lock_state = ST_IDLE;
`endif

  // Contested cycles go to the channel that did not win last time.
  assign grant_any = elig0 || elig1;
  assign grant_sel = (elig0 && elig1) ? !last_grant : elig1;
  assign accept    = load_en && grant_any;
  assign in0_ready = accept && !grant_sel;
  assign in1_ready = accept && grant_sel;
  assign acc_data  = grant_sel ? in1_data : in0_data;
  assign acc_last  = grant_sel ? in1_last : in0_last;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid  <= 1'b0;
      out_data   <= '0;
      out_last   <= 1'b0;
      out_src    <= 1'b0;
      last_grant <= 1'b1;
    end else if (load_en) begin
      out_valid <= accept;
      if (accept) begin
        out_data   <= acc_data;
        out_last   <= acc_last;
        out_src    <= grant_sel;
        last_grant <= grant_sel;
      end
    end
  end

endmodule

// File: tb/tb_stream_mux2_rr.sv
// Bench for stream_mux2_rr: directed steps then random traffic against a transaction-level model.
// Build with or without MUX_PKT_LOCK_EN to match the design configuration.
module tb_stream_mux2_rr;
  localparam int DATA_W = 8;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              in0_valid, in0_last, in0_ready;
  logic [DATA_W-1:0] in0_data;
  logic              in1_valid, in1_last, in1_ready;
  logic [DATA_W-1:0] in1_data;
  logic              out_valid, out_last, out_src, out_ready;
  logic [DATA_W-1:0] out_data;

  stream_mux2_rr #(.DATA_W(DATA_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .in0_valid(in0_valid), .in0_data(in0_data), .in0_last(in0_last), .in0_ready(in0_ready),
    .in1_valid(in1_valid), .in1_data(in1_data), .in1_last(in1_last), .in1_ready(in1_ready),
    .out_valid(out_valid), .out_data(out_data), .out_last(out_last), .out_src(out_src),
    .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  int n_pass = 0;
  int n_total = 0;

  // Source queues hold {last, data}; the scoreboard holds {src, last, data}.
  logic [DATA_W:0]   src_q0[$];
  logic [DATA_W:0]   src_q1[$];
  logic [DATA_W+1:0] exp_q[$];
  logic [DATA_W-1:0] out_log[$];
  logic              src_log[$];
  bit                en0, en1;

  // Reference model: output slot contents, last winner, and the channel owning an open packet.
  bit                m_valid, m_last, m_src;
  logic [DATA_W-1:0] m_data;
  int                m_prev, m_lock, open_src;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic model_reset();
    m_valid = 0; m_last = 0; m_src = 0; m_data = '0;
    m_prev = 1; m_lock = -1; open_src = -1;
    exp_q.delete(); src_q0.delete(); src_q1.delete();
  endtask

  task automatic drive();
    in0_valid = en0 && (src_q0.size() > 0);
    in0_data  = (src_q0.size() > 0) ? src_q0[0][DATA_W-1:0] : '0;
    in0_last  = (src_q0.size() > 0) ? src_q0[0][DATA_W] : 1'b0;
    in1_valid = en1 && (src_q1.size() > 0);
    in1_data  = (src_q1.size() > 0) ? src_q1[0][DATA_W-1:0] : '0;
    in1_last  = (src_q1.size() > 0) ? src_q1[0][DATA_W] : 1'b0;
  endtask

  task automatic add_pkt(input int ch, input int len, input logic [DATA_W-1:0] base);
    for (int i = 0; i < len; i++) begin
      if (ch == 0) src_q0.push_back({(i == len - 1), base + DATA_W'(i)});
      else         src_q1.push_back({(i == len - 1), base + DATA_W'(i)});
    end
  endtask

  // One clock cycle: entered at posedge+1 with inputs driven, leaves at the next posedge+1.
  task automatic step();
    bit can_load, e0, e1;
    int pick;
    logic [DATA_W+1:0] beat, got;
    @(negedge clk);
    check("out_valid", out_valid, m_valid);
    check("out_data", out_data, m_data);
    check("out_last", out_last, m_last);
    check("out_src", out_src, m_src);

    can_load = !m_valid || out_ready;
    e0 = in0_valid && (m_lock < 0 || m_lock == 0);
    e1 = in1_valid && (m_lock < 0 || m_lock == 1);
    pick = -1;
    if (e0 && e1) pick = 1 - m_prev;
    else if (e0)  pick = 0;
    else if (e1)  pick = 1;
    check("in0_ready", in0_ready, can_load && pick == 0);
    check("in1_ready", in1_ready, can_load && pick == 1);

    if (out_valid && out_ready) begin
      got = {out_src, out_last, out_data};
      check("sb_nonempty", exp_q.size() != 0, 1);
      if (exp_q.size() != 0) check("sb_beat", got, exp_q.pop_front());
      out_log.push_back(out_data);
      src_log.push_back(out_src);
`ifdef MUX_PKT_LOCK_EN
      if (open_src >= 0) check("no_interleave", out_src, open_src);
      open_src = out_last ? -1 : int'(out_src);
`endif
    end

    if (can_load) begin
      if (pick >= 0) begin
        beat = (pick == 1) ? {1'b1, in1_last, in1_data} : {1'b0, in0_last, in0_data};
        exp_q.push_back(beat);
        m_valid = 1; m_src = beat[DATA_W+1]; m_last = beat[DATA_W]; m_data = beat[DATA_W-1:0];
        m_prev = pick;
`ifdef MUX_PKT_LOCK_EN
        m_lock = beat[DATA_W] ? -1 : pick;
`endif
      end else begin
        m_valid = 0;
      end
    end

    if (in0_valid && in0_ready) void'(src_q0.pop_front());
    if (in1_valid && in1_ready) void'(src_q1.pop_front());
    @(posedge clk);
    #1;
    drive();
  endtask

  task automatic check_log(input string tag, input logic [DATA_W-1:0] a, b, c, d);
    logic [DATA_W-1:0] want[4];
    want = '{a, b, c, d};
    check({tag, "_count"}, out_log.size(), 4);
    for (int i = 0; i < 4 && i < out_log.size(); i++) check(tag, out_log[i], want[i]);
  endtask

  initial begin
    en0 = 0; en1 = 0; out_ready = 0;
    model_reset();
    drive();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_out_src", out_src, 0);
    rst_n = 1'b1;

    // Single beat on ch0: ready now, on the output next cycle, gone the cycle after.
    add_pkt(0, 1, 8'h11); en0 = 1; out_ready = 1; drive();
    #1 check("t1_in0_ready", in0_ready, 1);
    step();
    check("t1_out_valid", out_valid, 1);
    check("t1_out_data", out_data, 8'h11);
    check("t1_out_src", out_src, 0);
    step();
    check("t1_drained", out_valid, 0);

    // Continuous contested single-beat traffic alternates with no bubbles.
    for (int i = 0; i < 6; i++) begin
      add_pkt(0, 1, 8'hA0 + 8'(i));
      add_pkt(1, 1, 8'hB0 + 8'(i));
    end
    en1 = 1; drive(); src_log.delete();
    repeat (13) step();
    check("t2_beats", src_log.size(), 12);
    for (int i = 1; i < src_log.size(); i++) check("t2_alternate", src_log[i] != src_log[i-1], 1);

    // Backpressure holds the output beat and blocks both inputs.
    en1 = 0; out_ready = 0;
    add_pkt(0, 1, 8'h5A); add_pkt(0, 1, 8'h5B); drive();
    step();
    for (int i = 0; i < 3; i++) begin
      step();
      check("t3_hold_data", out_data, 8'h5A);
    end
    out_ready = 1; drive();
    step();
    check("t3_next_data", out_data, 8'h5B);
    repeat (2) step();

    // 3-beat ch0 packet against a waiting ch1 beat.
    out_log.delete();
    add_pkt(0, 3, 8'h01); add_pkt(1, 1, 8'hF0); en0 = 1; en1 = 0; drive();
    step();
    en1 = 1; drive();
    repeat (6) step();
`ifdef MUX_PKT_LOCK_EN
    check_log("t4_order", 8'h01, 8'h02, 8'h03, 8'hF0);
`else
    check_log("t4_order", 8'h01, 8'hF0, 8'h02, 8'h03);
`endif

    // ch0 pauses mid-packet while ch1 is waiting.
    out_log.delete();
    add_pkt(0, 3, 8'h21); add_pkt(1, 1, 8'hE0); en0 = 1; en1 = 0; drive();
    step();
    en0 = 0; en1 = 1; drive();
    repeat (2) step();
    en0 = 1; drive();
    repeat (5) step();
`ifdef MUX_PKT_LOCK_EN
    check_log("t5_order", 8'h21, 8'h22, 8'h23, 8'hE0);
`else
    check_log("t5_order", 8'h21, 8'hE0, 8'h22, 8'h23);
`endif

    // Reset mid-packet with a beat in flight.
    add_pkt(0, 3, 8'h31); en0 = 1; en1 = 0; out_ready = 0; drive();
    step();
    check("t6_pre_valid", out_valid, 1);
    #2 rst_n = 1'b0;
    #1 check("t6_async_clear", out_valid, 0);
    model_reset();
    rst_n = 1'b1;
    add_pkt(0, 1, 8'h41); add_pkt(1, 1, 8'h51); en0 = 1; en1 = 1; out_ready = 1; drive();
    #1 check("t6_ch0_first", in0_ready, 1);
    check("t6_ch1_wait", in1_ready, 0);
    @(posedge clk);
    #1 drive();
    m_valid = 1; m_data = 8'h41; m_last = 1; m_src = 0; m_prev = 0;
    exp_q.push_back({1'b0, 1'b1, 8'h41});
    void'(src_q0.pop_front());
    drive();
    repeat (3) step();

    // Random packets, valids and backpressure.
    for (int cyc = 0; cyc < 400; cyc++) begin
      if (src_q0.size() < 4) add_pkt(0, $urandom_range(1, 4), 8'($urandom));
      if (src_q1.size() < 4) add_pkt(1, $urandom_range(1, 4), 8'($urandom));
      en0 = ($urandom_range(0, 3) != 0);
      en1 = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      drive();
      step();
    end

    en0 = 1; en1 = 1; out_ready = 1; drive();
    for (int cyc = 0; cyc < 200 && (src_q0.size() + src_q1.size() + exp_q.size()) != 0; cyc++) step();
    check("drain_empty", src_q0.size() + src_q1.size() + exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
